imem_responder: RTL and testbench

//  Responder end of the instruction-memory request/response interface driven by the IFU.
//  - Accepts one fetch request (addr, valid, tag) every cycle; there is no ready signal.
//  - Returns rdata/valid/tag after a fixed RD_LATENCY, with the tag echoed unchanged.
//  - Holds the instruction store; a loader write port fills it before or while the core runs.

---
 rtl/imem_responder.sv | 190 +++++++++++++++++++
 tb/tb_imem_responder.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// ---------------------------------------------------------------------------
// imem_responder
//   Responder end of the IFU instruction-memory request/response interface.
//   One fetch is accepted per cycle (there is no ready). Each fetch returns
//   {rdata, tag, err} RD_LATENCY cycles later through a valid/tag/data shift
//   pipeline. The instruction store is filled through a byte-enabled loader
//   port, which may write while fetches are in progress.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words in the store (power of 2)
//   RD_LATENCY   request-to-response latency in cycles (1..4)
//   TAG_WIDTH    width of the echoed request tag
//   ADDR_WIDTH   byte-address width of the request and loader ports
//
// Ports
//   clk, rst_n             core clock, asynchronous active-low reset
//   req_addr/valid/tag     fetch request (byte address, strobe, tag)
//   flush                  kills every in-flight response and the current req
//   rsp_rdata/valid/tag    response word, one-cycle valid pulse, echoed tag
//   rsp_err                misaligned / out-of-range fetch (rdata = NOP)
//   ld_we/addr/wdata/be    loader write port (word-aligned, byte enables)
//
// Optional build macro
//   IMEM_STATS_EN  adds saturating counters stat_req_cnt, stat_rsp_cnt and
//                  stat_flush_drop_cnt as extra output ports.
// ---------------------------------------------------------------------------
module imem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned TAG_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic                  req_valid,
    input  logic [TAG_WIDTH-1:0]  req_tag,
    input  logic                  flush,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_valid,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    output logic                  rsp_err,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [31:0]           ld_wdata,
    input  logic [3:0]            ld_be
`ifdef IMEM_STATS_EN
    ,
    output logic [31:0]           stat_req_cnt,
    output logic [31:0]           stat_rsp_cnt,
    output logic [31:0]           stat_flush_drop_cnt
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] w_req_idx;
    logic [IDX_W-1:0] w_ld_idx;
    logic             w_req_err;
    logic             w_ld_ok;
    logic             w_unused_ld_lsb;

    assign w_req_idx = req_addr[IDX_W+1:2];
    assign w_ld_idx  = ld_addr[IDX_W+1:2];
    assign w_req_err = (req_addr[1:0] != 2'b00) | (|req_addr[ADDR_WIDTH-1:IDX_W+2]);
    // Out-of-range loader writes are dropped rather than wrapped.
    assign w_ld_ok   = ld_we & ~(|ld_addr[ADDR_WIDTH-1:IDX_W+2]);
    // Loader byte offset is ignored; the write is always word-aligned.
    assign w_unused_ld_lsb = ^ld_addr[1:0];

    // ------------------------------------------------------------------
    // Instruction store (not reset)
    // ------------------------------------------------------------------
    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (ld_be[b]) begin
                    r_mem[w_ld_idx][8*b +: 8] <= ld_wdata[8*b +: 8];
                end
            end
        end
    end

    // Write-first read: lanes being written this cycle to the same word are
    // forwarded from the loader so the fetch sees the merged new word.
    logic [31:0] w_rd_word;
    logic [31:0] w_rd_data;

    always_comb begin
        w_rd_word = r_mem[w_req_idx];
        for (int unsigned b = 0; b < 4; b++) begin
            if (w_ld_ok && (w_ld_idx == w_req_idx) && ld_be[b]) begin
                w_rd_word[8*b +: 8] = ld_wdata[8*b +: 8];
            end
        end
        w_rd_data = w_req_err ? NOP : w_rd_word;
    end

    // ------------------------------------------------------------------
    // Response pipeline: RD_LATENCY stages, last stage drives the outputs
    // ------------------------------------------------------------------
    logic [RD_LATENCY-1:0] r_vld;
    logic [RD_LATENCY-1:0] r_err;
    logic [31:0]           r_data [RD_LATENCY];
    logic [TAG_WIDTH-1:0]  r_tag  [RD_LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            r_err <= '0;
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                r_data[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            if (flush) begin
                r_vld <= '0;
            end else begin
                r_vld[0] <= req_valid;
                for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
            end
            // Stage 0 payload only loads on a request; bubbles keep the
            // previous payload while the valid bit carries the zero.
            if (req_valid) begin
                r_data[0] <= w_rd_data;
                r_tag[0]  <= req_tag;
                r_err[0]  <= w_req_err;
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                r_data[i] <= r_data[i-1];
                r_tag[i]  <= r_tag[i-1];
                r_err[i]  <= r_err[i-1];
            end
        end
    end

    assign rsp_valid = r_vld[RD_LATENCY-1];
    assign rsp_rdata = r_data[RD_LATENCY-1];
    assign rsp_tag   = r_tag[RD_LATENCY-1];
    assign rsp_err   = r_err[RD_LATENCY-1];

`ifdef IMEM_STATS_EN
    // ------------------------------------------------------------------
    // Saturating statistics counters
    // ------------------------------------------------------------------
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? '1 : s[31:0];
    endfunction

    // The last stage is already on the outputs when flush hits, so only
    // stages 0..RD_LATENCY-2 plus the incoming request count as killed.
    logic [31:0] w_kill_cnt;

    always_comb begin
        w_kill_cnt = 32'(req_valid);
        for (int unsigned i = 0; i + 1 < RD_LATENCY; i++) begin
            w_kill_cnt = w_kill_cnt + 32'(r_vld[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_req_cnt        <= '0;
            stat_rsp_cnt        <= '0;
            stat_flush_drop_cnt <= '0;
        end else begin
            if (req_valid && !flush) begin
                stat_req_cnt <= sat_add(stat_req_cnt, 32'd1);
            end
            if (rsp_valid) begin
                stat_rsp_cnt <= sat_add(stat_rsp_cnt, 32'd1);
            end
            if (flush) begin
                stat_flush_drop_cnt <= sat_add(stat_flush_drop_cnt, w_kill_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam int unsigned LAT = 3;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_addr;
    logic        req_valid;
    logic [31:0] req_tag;
    logic        flush;
    logic [31:0] rsp_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_tag;
    logic        rsp_err;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_wdata;
    logic [3:0]  ld_be;
`ifdef IMEM_STATS_EN
    logic [31:0] stat_req_cnt;
    logic [31:0] stat_rsp_cnt;
    logic [31:0] stat_flush_drop_cnt;
`endif

    imem_responder #(
        .DEPTH_WORDS (1024),
        .RD_LATENCY  (LAT),
        .TAG_WIDTH   (32),
        .ADDR_WIDTH  (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_addr  (req_addr),
        .req_valid (req_valid),
        .req_tag   (req_tag),
        .flush     (flush),
        .rsp_rdata (rsp_rdata),
        .rsp_valid (rsp_valid),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .ld_we     (ld_we),
        .ld_addr   (ld_addr),
        .ld_wdata  (ld_wdata),
        .ld_be     (ld_be)
`ifdef IMEM_STATS_EN
        ,
        .stat_req_cnt        (stat_req_cnt),
        .stat_rsp_cnt        (stat_rsp_cnt),
        .stat_flush_drop_cnt (stat_flush_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] tag;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] tag;
        logic [31:0] data;
        logic        err;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    logic mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                e = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL missing_rsp tag=%h due_cycle=%0d now=%0d", e.tag, e.due, cyc);
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp actual tag=%h data=%h required no response (cycle %0d)",
                             rsp_tag, rsp_rdata, cyc);
                end else begin
                    e = sb.pop_front();
                    if (rsp_rdata !== e.data || rsp_tag !== e.tag || rsp_err !== e.err || e.due != cyc) begin
                        errors++;
                        $display("FAIL rsp actual data=%h tag=%h err=%b cycle=%0d required data=%h tag=%h err=%b cycle=%0d",
                                 rsp_rdata, rsp_tag, rsp_err, cyc, e.data, e.tag, e.err, e.due);
                    end
                end
            end
        end
    end

    task automatic next_cycle();
        @(negedge clk);
        req_valid = 1'b0;
        flush     = 1'b0;
        ld_we     = 1'b0;
        ld_be     = 4'h0;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] t,
                         input logic [31:0] d, input logic e);
        exp_t x;
        req_valid = 1'b1;
        req_addr  = a;
        req_tag   = t;
        if (!flush) begin
            x.data = d;
            x.tag  = t;
            x.err  = e;
            x.due  = cyc + LAT;
            sb.push_back(x);
        end
    endtask

    // Everything not yet on the outputs is killed; call before issue().
    task automatic do_flush();
        flush = 1'b1;
        while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        next_cycle();
        ld_we    = 1'b1;
        ld_addr  = a;
        ld_wdata = d;
        ld_be    = be;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain actual pending=%0d required 0", name, sb.size());
        end
        sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; flush = 1'b0;
        ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_be = '0;

        vecs[0] = '{32'h0000_0000, 32'h100, 32'h0000_00A0, 1'b0};
        vecs[1] = '{32'h0000_0004, 32'h104, 32'h0000_00A1, 1'b0};
        vecs[2] = '{32'h0000_0008, 32'h108, 32'h0000_00A2, 1'b0};
        vecs[3] = '{32'h0000_000C, 32'h10C, 32'h0000_00A3, 1'b0};
        vecs[4] = '{32'h0000_0006, 32'h200, 32'h0000_0013, 1'b1};
        vecs[5] = '{32'h0000_1000, 32'h204, 32'h0000_0013, 1'b1};
        vecs[6] = '{32'h0000_0FFC, 32'h208, 32'hDEAD_BEEF, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h20C, 32'h0000_0013, 1'b1};
        vecs[8] = '{32'h0000_0003, 32'h210, 32'h0000_0013, 1'b1};
        vecs[9] = '{32'h0000_0010, 32'h214, 32'h0000_0044, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_tag",   rsp_tag,   32'h0);
        chk("rst_err",   {31'b0, rsp_err}, 32'h0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Preload; word 4 uses a non-aligned loader address, 0x1000 is out of range
        load(32'h0, 32'hA0, 4'hF);
        load(32'h4, 32'hA1, 4'hF);
        load(32'h8, 32'hA2, 4'hF);
        load(32'hC, 32'hA3, 4'hF);
        load(32'h13, 32'h44, 4'hF);
        load(32'h14, 32'h1122_3344, 4'hF);
        load(32'hFFC, 32'hDEAD_BEEF, 4'hF);
        load(32'h1000, 32'hBAD0_BAD0, 4'hF);

        // Back-to-back table
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            issue(vecs[i].addr, vecs[i].tag, vecs[i].data, vecs[i].err);
        end
        next_cycle();
        issue(32'h0, 32'h220, 32'hA0, 1'b0);   // no wrap from the 0x1000 load
        next_cycle();
        drain("table");

        // Write-first collision on word 5, then re-read the committed word
        next_cycle();
        ld_we = 1'b1; ld_addr = 32'h14; ld_be = 4'b0011; ld_wdata = 32'hAABB_CCDD;
        issue(32'h14, 32'h300, 32'h1122_CCDD, 1'b0);
        next_cycle();
        issue(32'h14, 32'h301, 32'h1122_CCDD, 1'b0);
        next_cycle();
        drain("collision");

        // Flush with two in flight plus one same-cycle; loader write during flush
        next_cycle(); issue(32'h0, 32'h400, 32'hA0, 1'b0);
        next_cycle(); issue(32'h4, 32'h401, 32'hA1, 1'b0);
        next_cycle(); do_flush(); issue(32'h8, 32'h402, 32'hA2, 1'b0);
        ld_we = 1'b1; ld_addr = 32'h18; ld_be = 4'hF; ld_wdata = 32'h0000_0066;
        next_cycle(); issue(32'hC, 32'h403, 32'hA3, 1'b0);
        next_cycle(); issue(32'h18, 32'h404, 32'h66, 1'b0);
        next_cycle();
        drain("flush");

        // Reset mid-operation
        next_cycle(); issue(32'h0, 32'h500, 32'hA0, 1'b0);
        next_cycle(); issue(32'h4, 32'h501, 32'hA1, 1'b0);
        next_cycle(); issue(32'h8, 32'h502, 32'hA2, 1'b0);
        next_cycle(); issue(32'hC, 32'h503, 32'hA3, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("midrst_valid", {31'b0, rsp_valid}, 32'h0);
        chk("midrst_rdata", rsp_rdata, 32'h0);
        chk("midrst_tag",   rsp_tag,   32'h0);
        chk("midrst_err",   {31'b0, rsp_err}, 32'h0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            chk("post_rst_valid", {31'b0, rsp_valid}, 32'h0);
        end
        next_cycle(); issue(32'h4, 32'h510, 32'hA1, 1'b0);  // array survives reset
        next_cycle();
        drain("post_rst");

`ifdef IMEM_STATS_EN
        rst_n = 1'b0;
        #1;
        chk("stat_req_rst",  stat_req_cnt, 32'd0);
        chk("stat_rsp_rst",  stat_rsp_cnt, 32'd0);
        chk("stat_drop_rst", stat_flush_drop_cnt, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            issue(32'h0, 32'h600 + 32'(i), 32'hA0, 1'b0);
        end
        next_cycle(); do_flush();
        next_cycle();
        drain("stats");
        chk("stat_req",  stat_req_cnt, 32'd10);
        chk("stat_rsp",  stat_rsp_cnt, 32'd8);
        chk("stat_drop", stat_flush_drop_cnt, 32'd2);
`endif

        repeat (2) next_cycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
